fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 123 ++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with IF/ID register, one-entry skid and redirect
// Synchronous instruction memory: data returns the cycle after imem_rd, tracked by pend_q/pend_pc_q.
module fetch_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic [15:0] imem_addr,
  output logic        imem_rd,
  input  logic [15:0] imem_data,
  output logic [15:0] pc_out,
  output logic [15:0] inst_out,
  output logic [15:0] npc_out,
  output logic        valid_out
);

  typedef enum logic [1:0] {IDLE, RUN, STALL} state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] pend_pc_q, pend_pc_d;
  logic [15:0] inst_q, inst_d;
  logic [15:0] npc_q, npc_d;
  logic [15:0] skid_inst_q, skid_inst_d;
  logic [15:0] skid_npc_q, skid_npc_d;
  logic        pend_q, pend_d;
  logic        valid_q, valid_d;
  logic        skid_valid_q, skid_valid_d;
  logic        rd;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pend_pc_d    = pend_pc_q;
    inst_d       = inst_q;
    npc_d        = npc_q;
    skid_inst_d  = skid_inst_q;
    skid_npc_d   = skid_npc_q;
    pend_d       = pend_q;
    valid_d      = valid_q;
    skid_valid_d = skid_valid_q;
    rd           = 1'b0;
    case (state_q)
      IDLE: state_d = RUN;
      RUN, STALL: begin
        if (redirect) begin
          pc_d         = redirect_pc;
          pend_d       = 1'b0;
          skid_valid_d = 1'b0;
          valid_d      = 1'b0;
          state_d      = stall ? STALL : RUN;
        end else if (stall) begin
          // A return landing while stalled parks in the skid; STALL never issues, so pend_q is 0 there.
          if (pend_q) begin
            skid_inst_d  = imem_data;
            skid_npc_d   = pend_pc_q + 16'd1;
            skid_valid_d = 1'b1;
          end
          pend_d  = 1'b0;
          state_d = STALL;
        end else begin
          rd        = 1'b1;
          pc_d      = pc_q + 16'd1;
          pend_d    = 1'b1;
          pend_pc_d = pc_q;
          state_d   = RUN;
          if (state_q == STALL) begin
            if (skid_valid_q) begin
              inst_d  = skid_inst_q;
              npc_d   = skid_npc_q;
              valid_d = 1'b1;
            end else begin
              valid_d = 1'b0;
            end
            skid_valid_d = 1'b0;
          end else if (pend_q) begin
            inst_d  = imem_data;
            npc_d   = pend_pc_q + 16'd1;
            valid_d = 1'b1;
          end else begin
            valid_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      pc_q         <= 16'h0000;
      pend_pc_q    <= 16'h0000;
      inst_q       <= 16'h0000;
      npc_q        <= 16'h0000;
      skid_inst_q  <= 16'h0000;
      skid_npc_q   <= 16'h0000;
      pend_q       <= 1'b0;
      valid_q      <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pend_pc_q    <= pend_pc_d;
      inst_q       <= inst_d;
      npc_q        <= npc_d;
      skid_inst_q  <= skid_inst_d;
      skid_npc_q   <= skid_npc_d;
      pend_q       <= pend_d;
      valid_q      <= valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign imem_rd   = rd;
  assign imem_addr = pc_q;
  assign pc_out    = pc_q;
  assign inst_out  = inst_q;
  assign npc_out   = npc_q;
  assign valid_out = valid_q;

endmodule
